// File: rtl/instruction_fetch_unit.sv
// Purpose: owns the PC, fetches one word per instruction over imem req/ready, holds it for decode.
// Latency: ready in the first FETCH cycle gives instr_valid on the next cycle.
// Backpressure: waits in FETCH for imem_ready (bounded by TIMEOUT), holds ISSUE until instr_ack.
module instruction_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic [63:0] pc,
    input  logic        instr_ack,
    input  logic        branch_taken,
    input  logic [63:0] branch_imm,
    output logic        halted,
    output logic [1:0]  err_code,
    output logic [31:0] instr_count
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_ZERO  = 2'd1;
    localparam logic [1:0] ERR_ALIGN = 2'd2;
    localparam logic [1:0] ERR_TMO   = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ISSUE,
        HALT
    } state_t;

    state_t         state_q, state_d;
    logic [63:0]    pc_q, pc_d;
    logic [31:0]    instr_q, instr_d;
    logic [31:0]    count_q, count_d;
    logic [1:0]     err_q, err_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic [63:0]    next_pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            count_q <= '0;
            err_q   <= ERR_NONE;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            count_q <= count_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        count_d = count_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        // branch_imm is in halfword units, so the byte offset is imm << 1
        next_pc = branch_taken ? (pc_q + (branch_imm << 1)) : (pc_q + 64'd4);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    tmo_d   = '0;
                end
            end
            FETCH: begin
                if (imem_ready) begin
                    if (imem_rdata != 32'd0) begin
                        instr_d = imem_rdata;
                        state_d = ISSUE;
                    end else begin
                        err_d   = ERR_ZERO;
                        state_d = HALT;
                    end
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if (tmo_q == TMO_LAST) begin
                        err_d   = ERR_TMO;
                        state_d = HALT;
                    end
                end
            end
            ISSUE: begin
                if (instr_ack) begin
                    count_d = count_q + 32'd1;
                    // a misaligned target still retires the current instruction
                    if (next_pc[1:0] != 2'b00) begin
                        err_d   = ERR_ALIGN;
                        state_d = HALT;
                    end else begin
                        pc_d    = next_pc;
                        tmo_d   = '0;
                        state_d = FETCH;
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign instruction = instr_q;
    assign instr_valid = (state_q == ISSUE);
    assign pc          = pc_q;
    assign halted      = (state_q == HALT);
    assign err_code    = err_q;
    assign instr_count = count_q;

endmodule
